wb_ctrl: RTL and testbench

Writeback controller that drives the register file write port (AddrD/DataD/RegWEn) of the RISC-V core. It merges single-cycle ALU results with multi-cycle load results: it issues one load to data memory at a time, waits for the response, and formats the data per funct3 and byte offset. It exports a one-entry scoreboard so decode can stall consumers of a pending load destination.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_load_fmt.sv | 29 ++
 rtl/wb_ctrl.sv | 154 +++++++++++++++
 tb/tb_wb_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback controller: load encodings, FSM states
// and the load legality check used at issue time.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    // A load is legal when funct3 is a known type and the byte offset is
    // naturally aligned for the access size.
    function automatic logic legal_load(input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = (off[0] == 1'b0);
            F3_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load data formatter: selects the byte/half lane from a
// little-endian read word and sign- or zero-extends it per funct3.
module load_fmt
    import wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{off, 3'b000} +: 8];
        half_lane = rdata[{off[1], 4'b0000} +: 16];
        result    = 32'h0000_0000;
        case (funct3)
            F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   result = {{16{half_lane[15]}}, half_lane};
            F3_LW:   result = rdata;
            F3_LBU:  result = {24'h00_0000, byte_lane};
            F3_LHU:  result = {16'h0000, half_lane};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates the single register file write port between
// ALU results and one outstanding multi-cycle load, with a one-entry scoreboard.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  AddrD,
    output logic [31:0] DataD,
    output logic        RegWEn,
    output logic        pend_valid,
    output logic [4:0]  pend_rd,
    output logic        ld_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    wb_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]  f3_q, f3_next;
    logic [1:0]  off_q, off_next;

    logic [4:0]  addr_d_next;
    logic [31:0] data_d_next;
    logic        we_next;
    logic        mem_req_next;
    logic [31:0] mem_addr_next;
    logic        pend_valid_next;
    logic [4:0]  pend_rd_next;
    logic        ld_err_next;

    logic        load_done;
    logic [31:0] fmt_data;

    load_fmt u_load_fmt (
        .rdata  (mem_rdata),
        .funct3 (f3_q),
        .off    (off_q),
        .result (fmt_data)
    );

    // A returning load owns the write port, so the ALU is held off that cycle.
    assign load_done = (state == WAIT_MEM) && mem_rvalid;
    assign alu_ready = !load_done;
    assign ld_ready  = (state == IDLE);

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        f3_next         = f3_q;
        off_next        = off_q;
        addr_d_next     = AddrD;
        data_d_next     = DataD;
        we_next         = 1'b0;
        mem_req_next    = 1'b0;
        mem_addr_next   = mem_addr;
        pend_valid_next = pend_valid;
        pend_rd_next    = pend_rd;
        ld_err_next     = 1'b0;

        if (load_done) begin
            addr_d_next = pend_rd;
            data_d_next = fmt_data;
            we_next     = (pend_rd != 5'd0);
        end else if (alu_valid) begin
            addr_d_next = alu_rd;
            data_d_next = alu_data;
            we_next     = (alu_rd != 5'd0);
        end

        case (state)
            IDLE: begin
                if (ld_valid) begin
                    if (legal_load(ld_funct3, ld_addr[1:0])) begin
                        mem_req_next    = 1'b1;
                        mem_addr_next   = {ld_addr[31:2], 2'b00};
                        pend_valid_next = 1'b1;
                        pend_rd_next    = ld_rd;
                        f3_next         = ld_funct3;
                        off_next        = ld_addr[1:0];
                        cnt_next        = '0;
                        state_next      = WAIT_MEM;
                    end else begin
                        ld_err_next = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    pend_valid_next = 1'b0;
                    cnt_next        = '0;
                    state_next      = IDLE;
                end else if (cnt == CNT_LAST) begin
                    ld_err_next     = 1'b1;
                    pend_valid_next = 1'b0;
                    cnt_next        = '0;
                    state_next      = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            AddrD      <= 5'd0;
            DataD      <= 32'h0000_0000;
            RegWEn     <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            pend_valid <= 1'b0;
            pend_rd    <= 5'd0;
            ld_err     <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            f3_q       <= f3_next;
            off_q      <= off_next;
            AddrD      <= addr_d_next;
            DataD      <= data_d_next;
            RegWEn     <= we_next;
            mem_req    <= mem_req_next;
            mem_addr   <= mem_addr_next;
            pend_valid <= pend_valid_next;
            pend_rd    <= pend_rd_next;
            ld_err     <= ld_err_next;
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed self-checking bench for wb_ctrl: ALU writes, load formatting,
// write-port collisions, illegal loads, timeout and reset during a load.
module tb_wb_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  AddrD;
    logic [31:0] DataD;
    logic        RegWEn;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        ld_err;

    int vectors;
    int miscompares;

    wb_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_funct3  (ld_funct3),
        .ld_addr    (ld_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .AddrD      (AddrD),
        .DataD      (DataD),
        .RegWEn     (RegWEn),
        .pend_valid (pend_valid),
        .pend_rd    (pend_rd),
        .ld_err     (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid  = 1'b0;
        alu_rd     = 5'd0;
        alu_data   = 32'h0;
        ld_valid   = 1'b0;
        ld_rd      = 5'd0;
        ld_funct3  = 3'b000;
        ld_addr    = 32'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    // Issue a load and return data in the first WAIT_MEM cycle; leaves the
    // bench one cycle after the completion edge.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata);
        ld_valid  = 1'b1;
        ld_rd     = rd;
        ld_funct3 = f3;
        ld_addr   = addr;
        step();
        ld_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        #1;
        vectors++; if (AddrD !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_AddrD: got %0d expected 0", AddrD); end
        vectors++; if (DataD !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_DataD: got %h expected 0", DataD); end
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_RegWEn: got %b expected 0", RegWEn); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        vectors++; if (pend_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pend_valid: got %b expected 0", pend_valid); end
        vectors++; if (pend_rd !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_pend_rd: got %0d expected 0", pend_rd); end
        vectors++; if (ld_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ld_err: got %b expected 0", ld_err); end
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ld_ready: got %b expected 1", ld_ready); end
        vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_alu_ready: got %b expected 1", alu_ready); end
    endtask

    task automatic test_alu_burst();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        step();
        alu_rd   = 5'd0;
        alu_data = 32'h0000_0001;
        vectors++; if (AddrD !== 5'd5) begin miscompares++; $display("[TB] FAIL alu1_AddrD: got %0d expected 5", AddrD); end
        vectors++; if (DataD !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL alu1_DataD: got %h expected deadbeef", DataD); end
        vectors++; if (RegWEn !== 1'b1) begin miscompares++; $display("[TB] FAIL alu1_RegWEn: got %b expected 1", RegWEn); end
        step();
        alu_valid = 1'b0;
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL alu_x0_RegWEn: got %b expected 0", RegWEn); end
        vectors++; if (DataD !== 32'h1) begin miscompares++; $display("[TB] FAIL alu_x0_DataD: got %h expected 1", DataD); end
        step();
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL alu_idle_RegWEn: got %b expected 0", RegWEn); end
        vectors++; if (DataD !== 32'h1) begin miscompares++; $display("[TB] FAIL alu_hold_DataD: got %h expected 1", DataD); end
    endtask

    task automatic test_lb();
        ld_valid  = 1'b1;
        ld_rd     = 5'd7;
        ld_funct3 = 3'b000;
        ld_addr   = 32'h0000_0103;
        step();
        ld_valid = 1'b0;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL lb_mem_req: got %b expected 1", mem_req); end
        vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL lb_mem_addr: got %h expected 100", mem_addr); end
        vectors++; if (pend_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL lb_pend_valid: got %b expected 1", pend_valid); end
        vectors++; if (pend_rd !== 5'd7) begin miscompares++; $display("[TB] FAIL lb_pend_rd: got %0d expected 7", pend_rd); end
        vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_ld_ready: got %b expected 0", ld_ready); end
        step();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_mem_req_once: got %b expected 0", mem_req); end
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8012_3456;
        #1;
        vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_alu_ready: got %b expected 0", alu_ready); end
        step();
        mem_rvalid = 1'b0;
        vectors++; if (DataD !== 32'hFFFF_FF80) begin miscompares++; $display("[TB] FAIL lb_DataD: got %h expected ffffff80", DataD); end
        vectors++; if (AddrD !== 5'd7) begin miscompares++; $display("[TB] FAIL lb_AddrD: got %0d expected 7", AddrD); end
        vectors++; if (RegWEn !== 1'b1) begin miscompares++; $display("[TB] FAIL lb_RegWEn: got %b expected 1", RegWEn); end
        vectors++; if (pend_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_pend_clear: got %b expected 0", pend_valid); end
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL lb_ld_ready_after: got %b expected 1", ld_ready); end
    endtask

    task automatic test_lhu_and_misaligned();
        do_load(5'd9, 3'b101, 32'h0000_0202, 32'hBEEF_0000);
        vectors++; if (DataD !== 32'h0000_BEEF) begin miscompares++; $display("[TB] FAIL lhu_DataD: got %h expected 0000beef", DataD); end
        vectors++; if (AddrD !== 5'd9) begin miscompares++; $display("[TB] FAIL lhu_AddrD: got %0d expected 9", AddrD); end
        vectors++; if (mem_addr !== 32'h200) begin miscompares++; $display("[TB] FAIL lhu_mem_addr: got %h expected 200", mem_addr); end
        ld_valid  = 1'b1;
        ld_rd     = 5'd10;
        ld_funct3 = 3'b001;
        ld_addr   = 32'h0000_0201;
        step();
        ld_valid = 1'b0;
        vectors++; if (ld_err !== 1'b1) begin miscompares++; $display("[TB] FAIL lh_mis_ld_err: got %b expected 1", ld_err); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL lh_mis_mem_req: got %b expected 0", mem_req); end
        vectors++; if (pend_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lh_mis_pend: got %b expected 0", pend_valid); end
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL lh_mis_ld_ready: got %b expected 1", ld_ready); end
        step();
        vectors++; if (ld_err !== 1'b0) begin miscompares++; $display("[TB] FAIL lh_mis_pulse: got %b expected 0", ld_err); end
        ld_valid  = 1'b1;
        ld_funct3 = 3'b011;
        ld_addr   = 32'h0000_0300;
        step();
        ld_valid = 1'b0;
        vectors++; if (ld_err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_f3_ld_err: got %b expected 1", ld_err); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL bad_f3_mem_req: got %b expected 0", mem_req); end
        ld_valid  = 1'b1;
        ld_funct3 = 3'b010;
        ld_addr   = 32'h0000_0302;
        step();
        ld_valid = 1'b0;
        vectors++; if (ld_err !== 1'b1) begin miscompares++; $display("[TB] FAIL lw_mis_ld_err: got %b expected 1", ld_err); end
        step();
    endtask

    task automatic test_formats();
        do_load(5'd1, 3'b001, 32'h0000_0000, 32'h1234_8001);
        vectors++; if (DataD !== 32'hFFFF_8001) begin miscompares++; $display("[TB] FAIL lh0_DataD: got %h expected ffff8001", DataD); end
        do_load(5'd2, 3'b001, 32'h0000_0002, 32'h7FFF_0000);
        vectors++; if (DataD !== 32'h0000_7FFF) begin miscompares++; $display("[TB] FAIL lh2_DataD: got %h expected 00007fff", DataD); end
        do_load(5'd3, 3'b010, 32'h0000_0010, 32'hCAFE_F00D);
        vectors++; if (DataD !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL lw_DataD: got %h expected cafef00d", DataD); end
        do_load(5'd4, 3'b100, 32'h0000_0021, 32'h0000_9A00);
        vectors++; if (DataD !== 32'h0000_009A) begin miscompares++; $display("[TB] FAIL lbu_DataD: got %h expected 0000009a", DataD); end
        do_load(5'd6, 3'b000, 32'h0000_0030, 32'hFFFF_FF7F);
        vectors++; if (DataD !== 32'h0000_007F) begin miscompares++; $display("[TB] FAIL lb0_DataD: got %h expected 0000007f", DataD); end
        do_load(5'd0, 3'b010, 32'h0000_0040, 32'h1111_1111);
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL ld_x0_RegWEn: got %b expected 0", RegWEn); end
    endtask

    task automatic test_collision();
        ld_valid  = 1'b1;
        ld_rd     = 5'd3;
        ld_funct3 = 3'b010;
        ld_addr   = 32'h0000_0040;
        step();
        ld_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        alu_valid  = 1'b1;
        alu_rd     = 5'd4;
        alu_data   = 32'h0000_0055;
        #1;
        vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL col_alu_ready: got %b expected 0", alu_ready); end
        step();
        mem_rvalid = 1'b0;
        vectors++; if (AddrD !== 5'd3) begin miscompares++; $display("[TB] FAIL col_ld_AddrD: got %0d expected 3", AddrD); end
        vectors++; if (DataD !== 32'h1111_2222) begin miscompares++; $display("[TB] FAIL col_ld_DataD: got %h expected 11112222", DataD); end
        vectors++; if (RegWEn !== 1'b1) begin miscompares++; $display("[TB] FAIL col_ld_RegWEn: got %b expected 1", RegWEn); end
        vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL col_alu_ready_after: got %b expected 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        vectors++; if (AddrD !== 5'd4) begin miscompares++; $display("[TB] FAIL col_alu_AddrD: got %0d expected 4", AddrD); end
        vectors++; if (DataD !== 32'h55) begin miscompares++; $display("[TB] FAIL col_alu_DataD: got %h expected 55", DataD); end
        vectors++; if (RegWEn !== 1'b1) begin miscompares++; $display("[TB] FAIL col_alu_RegWEn: got %b expected 1", RegWEn); end
        step();
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL col_idle_RegWEn: got %b expected 0", RegWEn); end
    endtask

    task automatic test_back_to_back();
        ld_valid  = 1'b1;
        ld_rd     = 5'd20;
        ld_funct3 = 3'b100;
        ld_addr   = 32'h0000_0502;
        alu_valid = 1'b1;
        alu_rd    = 5'd21;
        alu_data  = 32'hA5A5_0001;
        step();
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        vectors++; if (AddrD !== 5'd21) begin miscompares++; $display("[TB] FAIL b2b_alu_AddrD: got %0d expected 21", AddrD); end
        vectors++; if (DataD !== 32'hA5A5_0001) begin miscompares++; $display("[TB] FAIL b2b_alu_DataD: got %h expected a5a50001", DataD); end
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_mem_req: got %b expected 1", mem_req); end
        vectors++; if (mem_addr !== 32'h500) begin miscompares++; $display("[TB] FAIL b2b_mem_addr: got %h expected 500", mem_addr); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00C3_0000;
        step();
        mem_rvalid = 1'b0;
        vectors++; if (DataD !== 32'h0000_00C3) begin miscompares++; $display("[TB] FAIL b2b_lbu_DataD: got %h expected 000000c3", DataD); end
        vectors++; if (AddrD !== 5'd20) begin miscompares++; $display("[TB] FAIL b2b_lbu_AddrD: got %0d expected 20", AddrD); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_rvalid_RegWEn: got %b expected 0", RegWEn); end
    endtask

    task automatic test_timeout();
        ld_valid  = 1'b1;
        ld_rd     = 5'd12;
        ld_funct3 = 3'b010;
        ld_addr   = 32'h0000_0080;
        step();
        ld_valid = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            vectors++; if (pend_valid !== 1'b1 || ld_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_wait_%0d: got pend=%b err=%b expected pend=1 err=0", i, pend_valid, ld_err); end
            step();
        end
        vectors++; if (ld_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_ld_err: got %b expected 1", ld_err); end
        vectors++; if (pend_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL to_pend_valid: got %b expected 0", pend_valid); end
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL to_RegWEn: got %b expected 0", RegWEn); end
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL to_ld_ready: got %b expected 1", ld_ready); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL to_late_RegWEn: got %b expected 0", RegWEn); end
        vectors++; if (ld_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_err_pulse: got %b expected 0", ld_err); end
    endtask

    task automatic test_reset_mid_load();
        ld_valid  = 1'b1;
        ld_rd     = 5'd14;
        ld_funct3 = 3'b010;
        ld_addr   = 32'h0000_0090;
        step();
        ld_valid = 1'b0;
        vectors++; if (pend_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rml_pend_before: got %b expected 1", pend_valid); end
        rst = 1'b1;
        step();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #1;
        vectors++; if (pend_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rml_pend_valid: got %b expected 0", pend_valid); end
        vectors++; if (pend_rd !== 5'd0) begin miscompares++; $display("[TB] FAIL rml_pend_rd: got %0d expected 0", pend_rd); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rml_mem_addr: got %h expected 0", mem_addr); end
        vectors++; if (AddrD !== 5'd0 || DataD !== 32'h0) begin miscompares++; $display("[TB] FAIL rml_port: got %0d/%h expected 0/0", AddrD, DataD); end
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rml_ld_ready: got %b expected 1", ld_ready); end
        vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rml_alu_ready: got %b expected 1", alu_ready); end
        step();
        mem_rvalid = 1'b0;
        vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("[TB] FAIL rml_late_RegWEn: got %b expected 0", RegWEn); end
        vectors++; if (DataD !== 32'h0) begin miscompares++; $display("[TB] FAIL rml_late_DataD: got %h expected 0", DataD); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_alu_burst();
        test_lb();
        test_lhu_and_misaligned();
        test_formats();
        test_collision();
        test_back_to_back();
        test_timeout();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
